// File: rtl/mem_access_stage.sv
// MEM stage: EXE/MEM register, req/ack data-memory access (byte-lane stores, extended loads), MEM/WB register one cycle later plus wait cycles.
// mem_stall holds EXE/MEM and upstream while an access waits on dm_ack; `define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_stage #(
   parameter int DATA_WIDTH  = 32,
   parameter int BUS_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  EXE_MEM_DM_read,
   input  logic                  EXE_MEM_DM_write,
   input  logic [2:0]            EXE_MEM_function_3,
   input  logic                  EXE_MEM_rd_sel,
   input  logic [4:0]            EXE_MEM_rd_addr,
   input  logic [DATA_WIDTH-1:0] ALU_o,
   input  logic [DATA_WIDTH-1:0] Mux3_ALU,
   output logic                  dm_req,
   output logic                  dm_we,
   output logic [31:0]           dm_addr,
   output logic [3:0]            dm_wstrb,
   output logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic                  dm_ack,
   input  logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_stall,
   output logic [DATA_WIDTH-1:0] MEM_rd_data,
   output logic [4:0]            MEM_rd_addr,
   output logic                  MEM_rd_sel,
   output logic [DATA_WIDTH-1:0] MEM_WB_rd_data,
   output logic [4:0]            MEM_WB_rd_addr,
   output logic                  MEM_WB_rd_sel,
   output logic                  bus_err,
   output logic                  misalign
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam int          CW      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [31:0] TO_LAST = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;

   state_t                  state_q, state_d;
   logic [CW-1:0]           wait_cnt;
   logic                    ex_rd, ex_wr, ex_rsel;
   logic [2:0]              ex_f3;
   logic [4:0]              ex_raddr;
   logic [DATA_WIDTH-1:0]   ex_alu, ex_sdata;
   logic                    access, is_load, mis, timeout, req;
   logic [1:0]              a_lo, size;
   logic [3:0]              st_strb;
   logic [DATA_WIDTH-1:0]   st_data, ld_data, wb_data;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic                    bus_err_q, mis_q;

   assign a_lo    = ex_alu[1:0];
   assign size    = ex_f3[1:0];
   assign access  = ex_rd | ex_wr;
   assign is_load = ex_rd & ~ex_wr;

`ifdef MISALIGN_TRAP_EN
   assign mis = access & (((size == 2'b01) & a_lo[0]) | (size[1] & (a_lo != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   // The issue cycle counts as the first stall cycle, so the WAIT counter aborts one short of the limit.
   assign timeout   = (BUS_TIMEOUT > 0) && (state_q == WAIT) && access && !dm_ack
                      && (32'(wait_cnt) == TO_LAST);
   assign req       = !rst && access && !mis && !timeout;
   assign mem_stall = req & ~dm_ack;

   assign dm_req   = req;
   assign dm_we    = req & ex_wr;
   assign dm_addr  = {ex_alu[31:2], 2'b00};
   assign dm_wstrb = (req & ex_wr) ? st_strb : 4'b0000;
   assign dm_wdata = st_data;

   always_comb begin
      st_strb = 4'b1111;
      st_data = ex_sdata;
      case (size)
         2'b00: begin
            st_strb = 4'b0001 << a_lo;
            st_data = {4{ex_sdata[7:0]}};
         end
         2'b01: begin
            st_strb = a_lo[1] ? 4'b1100 : 4'b0011;
            st_data = {2{ex_sdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = dm_rdata[7:0];
      case (a_lo)
         2'd1:    ld_byte = dm_rdata[15:8];
         2'd2:    ld_byte = dm_rdata[23:16];
         2'd3:    ld_byte = dm_rdata[31:24];
         default: ;
      endcase
      ld_half = a_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (size)
         2'b00:   ld_data = ex_f3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = ex_f3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = dm_rdata;
      endcase
   end

   // A trapped access has no load data; the address is passed along instead.
   assign wb_data = (is_load && !mis) ? (timeout ? '0 : ld_data) : ex_alu;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_stall)  state_d = WAIT;
         WAIT:    if (!mem_stall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE)
            wait_cnt <= '0;
         else if (mem_stall)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rd    <= 1'b0;
         ex_wr    <= 1'b0;
         ex_rsel  <= 1'b0;
         ex_f3    <= 3'b000;
         ex_raddr <= 5'd0;
         ex_alu   <= '0;
         ex_sdata <= '0;
      end else if (!mem_stall) begin
         ex_rd    <= EXE_MEM_DM_read;
         ex_wr    <= EXE_MEM_DM_write;
         ex_rsel  <= EXE_MEM_rd_sel;
         ex_f3    <= EXE_MEM_function_3;
         ex_raddr <= EXE_MEM_rd_addr;
         ex_alu   <= ALU_o;
         ex_sdata <= Mux3_ALU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         MEM_WB_rd_data <= '0;
         MEM_WB_rd_addr <= 5'd0;
         MEM_WB_rd_sel  <= 1'b0;
         bus_err_q      <= 1'b0;
         mis_q          <= 1'b0;
      end else if (!mem_stall) begin
         MEM_WB_rd_data <= wb_data;
         MEM_WB_rd_addr <= ex_raddr;
         MEM_WB_rd_sel  <= ex_rsel & (ex_raddr != 5'd0) & ~mis;
         bus_err_q      <= timeout;
         mis_q          <= mis;
      end else begin
         MEM_WB_rd_sel  <= 1'b0;
         bus_err_q      <= 1'b0;
         mis_q          <= 1'b0;
      end
   end

   assign MEM_rd_data = ex_alu;
   assign MEM_rd_addr = ex_raddr;
   assign MEM_rd_sel  = ex_rsel;
   assign bus_err     = bus_err_q;
   assign misalign    = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage built with BUS_TIMEOUT=4; expected MEM/WB results go through a scoreboard queue.
module tb_mem_access_stage;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        sel;
      logic        err;
      logic        mis;
   } wb_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        EXE_MEM_DM_read, EXE_MEM_DM_write, EXE_MEM_rd_sel;
   logic [2:0]  EXE_MEM_function_3;
   logic [4:0]  EXE_MEM_rd_addr;
   logic [31:0] ALU_o, Mux3_ALU;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_wstrb;
   logic        mem_stall, MEM_rd_sel, MEM_WB_rd_sel, bus_err, misalign;
   logic [31:0] MEM_rd_data, MEM_WB_rd_data;
   logic [4:0]  MEM_rd_addr, MEM_WB_rd_addr;

   int      checks = 0;
   int      failures = 0;
   wb_exp_t sb[$];

   mem_access_stage #(.DATA_WIDTH(32), .BUS_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .EXE_MEM_DM_read(EXE_MEM_DM_read), .EXE_MEM_DM_write(EXE_MEM_DM_write),
      .EXE_MEM_function_3(EXE_MEM_function_3), .EXE_MEM_rd_sel(EXE_MEM_rd_sel),
      .EXE_MEM_rd_addr(EXE_MEM_rd_addr), .ALU_o(ALU_o), .Mux3_ALU(Mux3_ALU),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
      .MEM_rd_data(MEM_rd_data), .MEM_rd_addr(MEM_rd_addr), .MEM_rd_sel(MEM_rd_sel),
      .MEM_WB_rd_data(MEM_WB_rd_data), .MEM_WB_rd_addr(MEM_WB_rd_addr),
      .MEM_WB_rd_sel(MEM_WB_rd_sel), .bus_err(bus_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive_exe(input logic rd, input logic wr, input logic [2:0] f3, input logic rsel,
                            input logic [4:0] raddr, input logic [31:0] alu, input logic [31:0] sdata);
      EXE_MEM_DM_read    = rd;
      EXE_MEM_DM_write   = wr;
      EXE_MEM_function_3 = f3;
      EXE_MEM_rd_sel     = rsel;
      EXE_MEM_rd_addr    = raddr;
      ALU_o              = alu;
      Mux3_ALU           = sdata;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".mem_rd_data"}, MEM_rd_data, 32'h0);
      chk({tag, ".mem_rd_addr"}, 32'(MEM_rd_addr), 32'h0);
      chkb({tag, ".mem_rd_sel"}, MEM_rd_sel, 1'b0);
      chk({tag, ".wb_data"}, MEM_WB_rd_data, 32'h0);
      chk({tag, ".wb_addr"}, 32'(MEM_WB_rd_addr), 32'h0);
      chkb({tag, ".wb_sel"}, MEM_WB_rd_sel, 1'b0);
      chkb({tag, ".dm_req"}, dm_req, 1'b0);
      chkb({tag, ".dm_we"}, dm_we, 1'b0);
      chk({tag, ".dm_addr"}, dm_addr, 32'h0);
      chk({tag, ".dm_wstrb"}, 32'(dm_wstrb), 32'h0);
      chk({tag, ".dm_wdata"}, dm_wdata, 32'h0);
      chkb({tag, ".mem_stall"}, mem_stall, 1'b0);
      chkb({tag, ".bus_err"}, bus_err, 1'b0);
      chkb({tag, ".misalign"}, misalign, 1'b0);
   endtask

   // One instruction through EXE/MEM; ack_dly<0 means no ack. Completion is compared against the scoreboard head.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic rsel, input logic [4:0] raddr, input logic [31:0] alu,
                         input logic [31:0] sdata, input int ack_dly, input logic [31:0] rdata,
                         input logic [31:0] exp_wb, input logic exp_sel, input logic exp_err,
                         input logic exp_mis, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input int exp_stalls);
      wb_exp_t e;
      logic    acc, req_exp;
      bit      done;
      acc = (rd | wr) & ~exp_mis;
      @(negedge clk);
      drive_exe(rd, wr, f3, rsel, raddr, alu, sdata);
      e.data = exp_wb; e.addr = raddr; e.sel = exp_sel; e.err = exp_err; e.mis = exp_mis;
      sb.push_back(e);
      @(posedge clk); #1;
      chk({tag, ".mem_rd_data"}, MEM_rd_data, alu);
      chk({tag, ".mem_rd_addr"}, 32'(MEM_rd_addr), 32'(raddr));
      chkb({tag, ".mem_rd_sel"}, MEM_rd_sel, rsel);
      chkb({tag, ".wb_bubble"}, MEM_WB_rd_sel, 1'b0);
      chkb({tag, ".bus_err_idle"}, bus_err, 1'b0);
      chkb({tag, ".misalign_idle"}, misalign, 1'b0);
      drive_exe(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
      done = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge clk);
         dm_ack   = (k == ack_dly);
         dm_rdata = rdata;
         #1;
         req_exp = acc & ~(exp_err & (k == exp_stalls));
         chk($sformatf("%s.hold%0d", tag, k), MEM_rd_data, alu);
         if (k > 0) chkb($sformatf("%s.wb_sel_stall%0d", tag, k), MEM_WB_rd_sel, 1'b0);
         chkb($sformatf("%s.dm_req%0d", tag, k), dm_req, req_exp);
         chkb($sformatf("%s.mem_stall%0d", tag, k), mem_stall, logic'(k < exp_stalls));
         if (req_exp) begin
            chk($sformatf("%s.dm_addr%0d", tag, k), dm_addr, {alu[31:2], 2'b00});
            chkb($sformatf("%s.dm_we%0d", tag, k), dm_we, wr);
            chk($sformatf("%s.dm_wstrb%0d", tag, k), 32'(dm_wstrb), 32'(exp_strb));
            if (wr) chk($sformatf("%s.dm_wdata%0d", tag, k), dm_wdata, exp_wdata);
         end
         if (!mem_stall) done = 1'b1;
         @(posedge clk); #1;
         dm_ack = 1'b0;
      end
      chkb({tag, ".completed"}, done, 1'b1);
      e = sb.pop_front();
      chkb({tag, ".wb_sel"}, MEM_WB_rd_sel, e.sel);
      chk({tag, ".wb_addr"}, 32'(MEM_WB_rd_addr), 32'(e.addr));
      if (!e.mis) chk({tag, ".wb_data"}, MEM_WB_rd_data, e.data);
      chkb({tag, ".bus_err"}, bus_err, e.err);
      chkb({tag, ".misalign"}, misalign, e.mis);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      drive_exe(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      //     tag         rd   wr   f3      rsel rd     alu           sdata         ack  rdata         exp_wb        sel  err  mis  strb     wdata         stalls
      run_op("alu_x5",   1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'h0,        -1, 32'h0,        32'h0000_1234, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
      run_op("alu_x0",   1'b0, 1'b0, 3'b000, 1'b1, 5'd0, 32'h0000_5678, 32'h0,        -1, 32'h0,        32'h0000_5678, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
      run_op("sb",       1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_0103, 32'h0000_00AB, 0, 32'h0,        32'h0000_0103, 1'b0, 1'b0, 1'b0, 4'b1000, 32'hABAB_ABAB, 0);
      run_op("sh",       1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0000_0102, 32'h1234_CDEF, 2, 32'h0,        32'h0000_0102, 1'b0, 1'b0, 1'b0, 4'b1100, 32'hCDEF_CDEF, 2);
      run_op("sw",       1'b0, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0000_0200, 32'hDEAD_BEEF, 0, 32'h0,        32'h0000_0200, 1'b0, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 0);
      run_op("rd_wr",    1'b1, 1'b1, 3'b010, 1'b1, 5'd3, 32'h0000_0500, 32'h1122_3344, 1, 32'hFFFF_FFFF, 32'h0000_0500, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h1122_3344, 1);
      run_op("lh",       1'b1, 1'b0, 3'b001, 1'b1, 5'd8, 32'h0000_0102, 32'h0,        3, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        3);
      run_op("lhu",      1'b1, 1'b0, 3'b101, 1'b1, 5'd8, 32'h0000_0102, 32'h0,        3, 32'h80FF_7F01, 32'h0000_80FF, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        3);
      run_op("lb",       1'b1, 1'b0, 3'b000, 1'b1, 5'd4, 32'h0000_0101, 32'h0,        1, 32'h1234_F678, 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1);
      run_op("lbu",      1'b1, 1'b0, 3'b100, 1'b1, 5'd4, 32'h0000_0103, 32'h0,        0, 32'h1234_F678, 32'h0000_0012, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
      run_op("lw",       1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_0100, 32'h0,        0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
      run_op("lw_tmo",   1'b1, 1'b0, 3'b010, 1'b1, 5'd6, 32'h0000_0400, 32'h0,       -1, 32'h5555_AAAA, 32'h0,         1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        4);
      run_op("alu_post", 1'b0, 1'b0, 3'b000, 1'b1, 5'd9, 32'h0000_00C0, 32'h0,        -1, 32'h0,        32'h0000_00C0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
`ifdef MISALIGN_TRAP_EN
      run_op("lw_mis",   1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_0101, 32'h0,        0, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        0);
      run_op("lh_mis",   1'b1, 1'b0, 3'b001, 1'b1, 5'd7, 32'h0000_0103, 32'h0,        0, 32'h7ABC_0000, 32'h0,         1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,        0);
`else
      run_op("lw_mis",   1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_0101, 32'h0,        0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
      run_op("lh_mis",   1'b1, 1'b0, 3'b001, 1'b1, 5'd7, 32'h0000_0103, 32'h0,        0, 32'h7ABC_0000, 32'h0000_7ABC, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        0);
`endif

      // Reset asserted while a load sits in WAIT.
      @(negedge clk);
      drive_exe(1'b1, 1'b0, 3'b010, 1'b1, 5'd9, 32'h0000_0300, 32'h0);
      @(posedge clk); #1;
      drive_exe(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
      @(negedge clk); #1;
      chkb("rst_wait.issue_stall", mem_stall, 1'b1);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chkb("rst_wait.wait_req", dm_req, 1'b1);
      rst = 1'b1;
      #1;
      chkb("rst_wait.dm_req_drop", dm_req, 1'b0);
      chkb("rst_wait.stall_drop", mem_stall, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("post_rst");
      run_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 1'b1, 5'd10, 32'h0000_0600, 32'h0, 3, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
